// File: rtl/mul_shift_add.sv
// Sequential shift-and-add multiplier with a go/done four-phase handshake.
// Define MUL_SIGNED_EN for two's-complement operands and product; unsigned otherwise.
module mul_shift_add #(
  parameter int MCAND_W  = 8,
  parameter int MPLIER_W = 8
) (
  input  logic                        clk,
  input  logic                        reset_L,
  input  logic                        go,
  input  logic [MCAND_W-1:0]          mcandInput,
  input  logic [MPLIER_W-1:0]         mplierInput,
  output logic [MCAND_W+MPLIER_W-1:0] product,
  output logic                        done
);

  localparam int PROD_W = MCAND_W + MPLIER_W;
  localparam int CNT_W  = $clog2(MPLIER_W + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MPLIER_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_t;

  state_t state, state_next;

  logic [PROD_W-1:0]   mcand_sh;
  logic [PROD_W-1:0]   acc;
  logic [PROD_W-1:0]   acc_next;
  logic [PROD_W-1:0]   result;
  logic [PROD_W-1:0]   product_next;
  logic [MPLIER_W-1:0] mplier_sh;
  logic [CNT_W-1:0]    count;
  logic [MCAND_W-1:0]  mcand_mag;
  logic [MPLIER_W-1:0] mplier_mag;
  logic                load_product;

`ifdef MUL_SIGNED_EN
  logic mcand_neg;
  logic mplier_neg;

  // The most negative value negates to itself, which read unsigned is its true magnitude.
  assign mcand_mag  = mcandInput[MCAND_W-1] ? (~mcandInput + MCAND_W'(1)) : mcandInput;
  assign mplier_mag = mplierInput[MPLIER_W-1] ? (~mplierInput + MPLIER_W'(1)) : mplierInput;
  assign result     = (mcand_neg ^ mplier_neg) ? (~acc_next + PROD_W'(1)) : acc_next;
`else
  assign mcand_mag  = mcandInput;
  assign mplier_mag = mplierInput;
  assign result     = acc_next;
`endif

  assign acc_next = acc + (mplier_sh[0] ? mcand_sh : '0);

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    done         = 1'b1;
    load_product = 1'b0;
    product_next = '0;
    case (state)
      IDLE: begin
        if (go) begin
          state_next = RUN;
        end
      end
      RUN: begin
        done = 1'b0;
        // A zero operand is only visible unshifted on the first step.
        if (count == '0 && (mcand_sh == '0 || mplier_sh == '0)) begin
          state_next   = HOLD;
          load_product = 1'b1;
          product_next = '0;
        end else if (count == LAST_STEP) begin
          state_next   = HOLD;
          load_product = 1'b1;
          product_next = result;
        end
      end
      HOLD: begin
        if (!go) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      mcand_sh   <= '0;
      mplier_sh  <= '0;
      acc        <= '0;
      count      <= '0;
      product    <= '0;
`ifdef MUL_SIGNED_EN
      mcand_neg  <= 1'b0;
      mplier_neg <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            mcand_sh   <= PROD_W'(mcand_mag);
            mplier_sh  <= mplier_mag;
            acc        <= '0;
            count      <= '0;
`ifdef MUL_SIGNED_EN
            mcand_neg  <= mcandInput[MCAND_W-1];
            mplier_neg <= mplierInput[MPLIER_W-1];
`endif
          end
        end
        RUN: begin
          acc       <= acc_next;
          mcand_sh  <= mcand_sh << 1;
          mplier_sh <= mplier_sh >> 1;
          count     <= count + CNT_W'(1);
          if (load_product) begin
            product <= product_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
